// File: rtl/div_pkg.sv
// Shared types and constants for the integer divide control block.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int OP_REM = 1;
    localparam int OP_UNS = 0;

    localparam logic [31:0] INT32_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES32 = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_special.sv
// Detects divide-by-zero and signed overflow on prepared operands and
// produces the architecturally defined quotient/remainder for those cases.
module div_special
    import div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            is_signed,
    input  logic            word,
    output logic            is_special,
    output logic [XLEN-1:0] sp_quot,
    output logic [XLEN-1:0] sp_rem
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic div_zero;
    logic overflow;

    always_comb begin
        div_zero = word ? (b[31:0] == 32'h0) : (b == '0);
        overflow = 1'b0;
        if (is_signed) begin
            overflow = word ? (a[31:0] == INT32_MIN && b[31:0] == ALL_ONES32)
                            : (a == INT_MIN && b == '1);
        end
        is_special = div_zero | overflow;
        // Divide by zero takes priority; overflow returns the dividend as quotient.
        sp_quot    = div_zero ? '1 : a;
        sp_rem     = div_zero ? a  : '0;
    end

endmodule

// File: rtl/div_ctrl.sv
// Execute-stage control for the RV64M divide unit: operand preparation,
// special-case resolution, iterative divider sequencing and writeback handshake.
module div_ctrl
    import div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic            in_word,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [4:0]      in_rd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [4:0]      out_rd,
    output logic            div_in_valid,
    output logic [XLEN-1:0] div_a,
    output logic [XLEN-1:0] div_b,
    output logic            div_signed,
    output logic            div_flush,
    input  logic            div_result_valid,
    input  logic [XLEN-1:0] div_quotient,
    input  logic [XLEN-1:0] div_remainder
);

    state_t          state, state_nxt;
    logic [XLEN-1:0] prep_a, prep_b;
    logic            prep_signed;
    logic            sp_is;
    logic [XLEN-1:0] sp_quot, sp_rem;
    logic            accept;
    logic            op_rem, op_word;

    function automatic logic [XLEN-1:0] sel_result(input logic [XLEN-1:0] quot,
                                                   input logic [XLEN-1:0] rem_val,
                                                   input logic            rem,
                                                   input logic            word);
        logic [XLEN-1:0] v;
        v = rem ? rem_val : quot;
        // W results are always sign-extended from bit 31, even for unsigned ops.
        return word ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    always_comb begin
        prep_signed = !in_op[OP_UNS];
        prep_a      = in_rs1;
        prep_b      = in_rs2;
        if (in_word) begin
            if (prep_signed) begin
                prep_a = {{(XLEN-32){in_rs1[31]}}, in_rs1[31:0]};
                prep_b = {{(XLEN-32){in_rs2[31]}}, in_rs2[31:0]};
            end else begin
                prep_a = {{(XLEN-32){1'b0}}, in_rs1[31:0]};
                prep_b = {{(XLEN-32){1'b0}}, in_rs2[31:0]};
            end
        end
    end

    div_special #(.XLEN(XLEN)) u_special (
        .a          (prep_a),
        .b          (prep_b),
        .is_signed  (prep_signed),
        .word       (in_word),
        .is_special (sp_is),
        .sp_quot    (sp_quot),
        .sp_rem     (sp_rem)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        in_ready     = (state == IDLE);
        out_valid    = (state == DONE);
        div_in_valid = (state == LAUNCH);
        div_flush    = flush;
        accept       = in_valid && (state == IDLE) && !flush;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_valid) state_nxt = sp_is ? DONE : LAUNCH;
                LAUNCH:  state_nxt = WAIT;
                WAIT:    if (div_result_valid) state_nxt = DONE;
                DONE:    if (out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_a      <= '0;
            div_b      <= '0;
            div_signed <= 1'b0;
            op_rem     <= 1'b0;
            op_word    <= 1'b0;
            out_rd     <= '0;
            out_data   <= '0;
        end else if (accept) begin
            div_a      <= prep_a;
            div_b      <= prep_b;
            div_signed <= prep_signed;
            op_rem     <= in_op[OP_REM];
            op_word    <= in_word;
            out_rd     <= in_rd;
            if (sp_is) out_data <= sel_result(sp_quot, sp_rem, in_op[OP_REM], in_word);
        end else if (state == WAIT && div_result_valid && !flush) begin
            out_data <= sel_result(div_quotient, div_remainder, op_rem, op_word);
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: behavioural divider with fixed latency, plus a
// reference model of the RV64M divide/remainder results.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, in_word;
    logic [1:0]  in_op;
    logic [63:0] in_rs1, in_rs2;
    logic [4:0]  in_rd;
    logic        out_valid, out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic        div_in_valid, div_signed, div_flush;
    logic [63:0] div_a, div_b;
    logic        div_result_valid;
    logic [63:0] div_quotient, div_remainder;

    int errors = 0;
    int checks = 0;
    int launches = 0;

    logic        busy;
    int          dcnt;
    logic [63:0] la, lb;
    logic        ls;

    always #5 clk = ~clk;

    div_ctrl #(.XLEN(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_op            (in_op),
        .in_word          (in_word),
        .in_rs1           (in_rs1),
        .in_rs2           (in_rs2),
        .in_rd            (in_rd),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_rd           (out_rd),
        .div_in_valid     (div_in_valid),
        .div_a            (div_a),
        .div_b            (div_b),
        .div_signed       (div_signed),
        .div_flush        (div_flush),
        .div_result_valid (div_result_valid),
        .div_quotient     (div_quotient),
        .div_remainder    (div_remainder)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] divmod(input logic [63:0] a, input logic [63:0] b, input logic s);
        longint sa, sb;
        sa = a;
        sb = b;
        if (b == 64'h0) return {64'hFFFF_FFFF_FFFF_FFFF, a};
        if (s) return {64'(sa / sb), 64'(sa % sb)};
        return {a / b, a % b};
    endfunction

    // Returns {is_special, expected writeback value} from the RV64M rules.
    function automatic logic [64:0] ref_op(input logic [1:0] op, input logic word,
                                           input logic [63:0] rs1, input logic [63:0] rs2);
        logic uns, rem, sp;
        logic [63:0] q, r, res;
        longint sa, sb;
        int wa, wb;
        logic [31:0] ua, ub;
        uns = op[0];
        rem = op[1];
        sp  = 1'b0;
        if (word) begin
            ua = rs1[31:0];
            ub = rs2[31:0];
            wa = ua;
            wb = ub;
            if (ub == 32'h0) begin
                sp = 1'b1; q = '1; r = uns ? {32'h0, ua} : longint'(wa);
            end else if (!uns && ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF) begin
                sp = 1'b1; q = longint'(wa); r = '0;
            end else if (uns) begin
                q = {32'h0, ua / ub}; r = {32'h0, ua % ub};
            end else begin
                q = longint'(wa / wb); r = longint'(wa % wb);
            end
        end else begin
            sa = rs1;
            sb = rs2;
            if (rs2 == 64'h0) begin
                sp = 1'b1; q = '1; r = rs1;
            end else if (!uns && rs1 == 64'h8000_0000_0000_0000 && rs2 == '1) begin
                sp = 1'b1; q = rs1; r = '0;
            end else if (uns) begin
                q = rs1 / rs2; r = rs1 % rs2;
            end else begin
                q = sa / sb; r = sa % sb;
            end
        end
        res = rem ? r : q;
        if (word) res = {{32{res[31]}}, res[31:0]};
        return {sp, res};
    endfunction

    // Iterative divider stand-in: result pulse 65 cycles after the launch cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            busy             <= 1'b0;
            dcnt             <= 0;
            div_result_valid <= 1'b0;
            div_quotient     <= '0;
            div_remainder    <= '0;
        end else begin
            div_result_valid <= 1'b0;
            if (div_flush) begin
                busy <= 1'b0;
            end else if (div_in_valid) begin
                busy     <= 1'b1;
                dcnt     <= 1;
                la       <= div_a;
                lb       <= div_b;
                ls       <= div_signed;
                launches <= launches + 1;
            end else if (busy) begin
                if (dcnt == 64) begin
                    busy             <= 1'b0;
                    div_result_valid <= 1'b1;
                    {div_quotient, div_remainder} <= divmod(la, lb, ls);
                end else begin
                    dcnt <= dcnt + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (busy && !reset && !div_flush) begin
            chk("div_a_hold", div_a, la);
            chk("div_b_hold", div_b, lb);
            chk1("div_signed_hold", div_signed, ls);
        end
    end

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 7))
            0:       return 64'h0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h0000_0000_8000_0000;
            4:       return 64'h0000_0000_FFFF_FFFF;
            5:       return 64'($urandom_range(1, 50));
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    task automatic present(input logic [1:0] op, input logic word, input logic [63:0] rs1,
                           input logic [63:0] rs2, input logic [4:0] rd);
        in_valid = 1'b1;
        in_op    = op;
        in_word  = word;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_rd    = rd;
    endtask

    task automatic run_op(input logic [1:0] op, input logic word, input logic [63:0] rs1,
                          input logic [63:0] rs2, input logic [4:0] rd, input int stall,
                          input logic chk_a_en, input logic [63:0] chk_a);
        logic [64:0] r;
        logic [63:0] hold;
        int n, l0, exp_lat;
        r       = ref_op(op, word, rs1, rs2);
        exp_lat = r[64] ? 1 : 67;
        chk1("in_ready_idle", in_ready, 1'b1);
        present(op, word, rs1, rs2, rd);
        l0 = launches;
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            n++;
            if (n == 1) chk1("in_ready_busy", in_ready, 1'b0);
            if (chk_a_en && n == 5) chk("div_a_prep", div_a, chk_a);
        end while (!out_valid && n < 200);
        chk("latency", 64'(n), 64'(exp_lat));
        chk("out_data", out_data, r[63:0]);
        chk("out_rd", 64'(out_rd), 64'(rd));
        chk("launches", 64'(launches - l0), r[64] ? 64'd0 : 64'd1);
        hold = out_data;
        repeat (stall) begin
            @(negedge clk);
            chk1("stall_valid", out_valid, 1'b1);
            chk("stall_data", out_data, hold);
            chk1("stall_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk1("released_valid", out_valid, 1'b0);
        chk1("released_ready", in_ready, 1'b1);
    endtask

    initial begin
        int n, l0;
        reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid = 1'b0; in_op = 2'b00; in_word = 1'b0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        repeat (2) @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_div_in_valid", div_in_valid, 1'b0);
        chk("rst_out_data", out_data, 64'h0);
        chk("rst_out_rd", 64'(out_rd), 64'h0);
        chk("rst_div_a", div_a, 64'h0);
        chk("rst_div_b", div_b, 64'h0);
        chk1("rst_div_signed", div_signed, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd1, 0, 1'b0, 64'h0);
        run_op(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd2, 10, 1'b0, 64'h0);
        run_op(2'b01, 1'b0, 64'h1234, 64'h0, 5'd3, 0, 1'b0, 64'h0);
        run_op(2'b11, 1'b0, 64'h1234, 64'h0, 5'd4, 2, 1'b0, 64'h0);
        run_op(2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF, 5'd5, 0, 1'b0, 64'h0);
        run_op(2'b10, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF, 5'd6, 0, 1'b0, 64'h0);
        run_op(2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 0, 1'b0, 64'h0);
        run_op(2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 5'd8, 0, 1'b1, 64'h0000_0000_FFFF_FFFE);

        // Flush in WAIT, then a fresh op accepted the very next cycle
        present(2'b00, 1'b0, 64'd1000, 64'd3, 5'd9);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (29) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk1("flush_out_valid", out_valid, 1'b0);
        chk1("flush_in_ready", in_ready, 1'b1);
        run_op(2'b01, 1'b0, 64'd100, 64'd7, 5'd10, 0, 1'b0, 64'h0);

        // Flush coinciding with an accept: op must not be taken
        l0 = launches;
        present(2'b00, 1'b0, 64'd5, 64'd0, 5'd11);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        chk1("flush_acc_ready", in_ready, 1'b1);
        repeat (2) @(negedge clk);
        chk1("flush_acc_valid", out_valid, 1'b0);
        chk("flush_acc_launch", 64'(launches - l0), 64'd0);

        // Flush coinciding with the divider result: result discarded
        present(2'b00, 1'b0, 64'd77, 64'd5, 5'd12);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!div_result_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk1("result_seen", div_result_valid, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk1("flush_res_valid", out_valid, 1'b0);
        chk1("flush_res_ready", in_ready, 1'b1);
        @(negedge clk);
        chk1("flush_res_valid2", out_valid, 1'b0);

        // Randomized ops against the reference model
        for (int i = 0; i < 16; i++) begin
            run_op(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), pick(), pick(),
                   5'($urandom_range(0, 31)), int'($urandom_range(0, 3)), 1'b0, 64'h0);
        end

        // Asynchronous reset in the middle of WAIT
        present(2'b00, 1'b0, 64'd12345, 64'd67, 5'd13);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk1("arst_in_ready", in_ready, 1'b1);
        chk1("arst_out_valid", out_valid, 1'b0);
        chk1("arst_div_in_valid", div_in_valid, 1'b0);
        chk("arst_out_data", out_data, 64'h0);
        chk("arst_out_rd", 64'(out_rd), 64'h0);
        chk("arst_div_a", div_a, 64'h0);
        chk("arst_div_b", div_b, 64'h0);
        chk1("arst_div_signed", div_signed, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op(2'b10, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd3, 5'd14, 0, 1'b0, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Execute-stage control for the integer divide unit. It accepts RV64M divide/remainder micro-ops from issue and resolves divide-by-zero and signed overflow itself in one cycle. All other cases go to the iterative 64-bit divider, with operands held stable for the whole iteration. It returns one XLEN result per op to writeback through a valid/ready handshake and honours pipeline flush at any point.

## Interface
- XLEN, 64, datapath width; only 64 is supported.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  kills the in-flight op; also forwarded to the divider.
- in_valid  in  1  issue presents an op.
- in_ready  out  1  high only in IDLE; an op is accepted when in_valid & in_ready.
- in_op  in  2  bit1 = remainder (REM*), bit0 = unsigned (DIVU/REMU).
- in_word  in  1  32-bit W variant (DIVW/DIVUW/REMW/REMUW).
- in_rs1, in_rs2  in  XLEN  dividend, divisor.
- in_rd  in  5  destination tag, returned unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  writeback accepts; the transfer happens when out_valid & out_ready.
- out_data  out  XLEN  final result.
- out_rd  out  5  tag of the result.
- div_in_valid  out  1  one-cycle launch pulse to the divider.
- div_a, div_b  out  XLEN  divider operands; held constant from launch until div_result_valid.
- div_signed  out  1  signed divide; held with the operands.
- div_flush  out  1  equals flush combinationally.
- div_result_valid  in  1  divider done (one-cycle pulse).
- div_quotient, div_remainder  in  XLEN  divider results, valid with div_result_valid.

## Operation
- States:
  - IDLE: accept an op, then go to DONE if it is a special case, else to LAUNCH.
  - LAUNCH: assert div_in_valid for exactly one cycle, then go to WAIT.
  - WAIT: hold until div_result_valid; capture the result and go to DONE.
  - DONE: out_valid high; return to IDLE on out_ready.
- Operand preparation at accept, registered into div_a/div_b/div_signed:
  - Non-W: operands pass through as-is.
  - W, signed: operands are the low 32 bits sign-extended.
  - W, unsigned: operands are the low 32 bits zero-extended.
  - div_signed = !in_op[0].
- Special cases are evaluated on the prepared operands. W variants use 32-bit limits (divisor low 32 bits == 0; dividend == 0x8000_0000 and divisor == 0xFFFF_FFFF).
  - Divide by zero: quotient is all ones; remainder is the prepared dividend.
  - Signed overflow (most-negative / -1): quotient is the prepared dividend; remainder is 0.
  - Special cases never launch the divider.
- Result selection: quotient if in_op[1] == 0, else remainder. For W variants the low 32 bits are sign-extended to 64, including unsigned W ops.
- Flush: every state goes to IDLE at the next edge. out_valid drops and any captured or pending result is discarded. If flush and div_result_valid coincide, flush wins. If flush and an accept coincide, flush wins and the op is not accepted.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, div_in_valid 0, out_data 0, out_rd 0, div_a/div_b 0, div_signed 0.
- Special case: accepted in cycle t; out_valid in t+1.
- Normal case: accepted in t; div_in_valid in t+1; with the current divider, div_result_valid arrives in t+66 and out_valid in t+67. The block waits on div_result_valid and holds no latency counter.
- out_valid/out_data/out_rd are registered. They stay stable while out_ready is low, with no bound on the stall.
- in_ready is low from the accept edge until the edge on which DONE transfers. No back-to-back accept occurs in the transfer cycle.
- After a flush, the next accept is possible in the very next cycle. The divider is idle by then, so the launch in the following cycle is safe.

## Structure
- div_pkg holds:
  - the state enum (IDLE/LAUNCH/WAIT/DONE);
  - op bit positions (OP_REM = 1, OP_UNS = 0);
  - the 32-bit overflow constants (INT32_MIN, all-ones).
- One combinational sub-module, div_special. Its inputs are the prepared operands and the signed and word flags. Its outputs are is_special and the special quotient/remainder.

## Test plan
- DIV -7 / 2 (rs1 = 0xFFFF_FFFF_FFFF_FFF9, rs2 = 2) -> out_data 0xFFFF_FFFF_FFFF_FFFD at accept+67; REM of the same operands -> 0xFFFF_FFFF_FFFF_FFFF.
- DIVU x / 0 (rs1 = 0x1234) -> out_data 0xFFFF_FFFF_FFFF_FFFF at accept+1 with no div_in_valid; REMU of the same -> 0x1234.
- DIVW rs1 = 0x0000_0000_8000_0000, rs2 = 0xFFFF_FFFF -> out_data 0xFFFF_FFFF_8000_0000 at accept+1; REMW of the same -> 0.
- DIVUW rs1 = 0xFFFF_FFFF_FFFF_FFFE, rs2 = 1 -> out_data 0xFFFF_FFFF_FFFF_FFFE (sign-extended 0xFFFF_FFFE); div_a = 0xFFFF_FFFE and is stable through WAIT.
- Flush in WAIT cycle 30, then a DIVU 100/7 accepted the next cycle -> the first result is never output; the second gives out_data 14.
- Hold out_ready low for 10 cycles in DONE -> out_valid/out_data stable, in_ready 0; async reset mid-WAIT -> all outputs return to their reset values immediately.
